// File: rtl/mem_write_scoreboard.sv
// Memory write scoreboard: watches a memory write port and compares writes to a
// window of checkpoint addresses against a preloaded answer table.
//
// A run starts when checkpoint 0 is written with its expected value. After that,
// each checkpoint counts once, and every mismatch increments error_num. The run
// ends in REPORT when all checkpoints have been seen, or when the cycle limit
// expires. Only a reset leaves REPORT.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   ld_en/idx/data  answer-table load (IDLE only, readable byte order)
//   addr/data/wen   monitored memory write port (word address)
//   error_num       mismatch count, 255 = run not started
//   duration        cycles spent in CHECK
//   finish          high while in REPORT
//   timeout         REPORT was reached by the cycle limit
//   checked         number of distinct checkpoints seen
//   first_err_idx   index of first mismatch (all-ones = none)
//   first_err_data  compare-order data of first mismatch
module mem_write_scoreboard #(
  parameter int unsigned       ADDR_W      = 30,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       NUM_CHK     = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter bit                SWAP        = 1'b1,
  parameter logic [15:0]       TIMEOUT_CYC = 16'hFFFF,
  localparam int unsigned      IDX_W       = $clog2(NUM_CHK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  output logic [7:0]        error_num,
  output logic [15:0]       duration,
  output logic              finish,
  output logic              timeout,
  output logic [IDX_W:0]    checked,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data
);

  localparam logic [IDX_W:0] NumChkW = (IDX_W+1)'(NUM_CHK);

  typedef enum logic [1:0] {StIdle, StCheck, StReport} state_e;

  state_e              state_q, state_d;
  logic                wen_q;
  logic [7:0]          err_q, err_d;
  logic [15:0]         dur_q, dur_d;
  logic                tmo_q, tmo_d;
  logic [IDX_W:0]      chk_q, chk_d;
  logic [NUM_CHK-1:0]  done_q, done_d;
  logic                first_seen_q, first_seen_d;
  logic [IDX_W-1:0]    fidx_q, fidx_d;
  logic [DATA_W-1:0]   fdata_q, fdata_d;
  logic [9:0]          pen_sum;

  // Answer table has no reset so it survives between runs.
  logic [DATA_W-1:0]   table_q [NUM_CHK];

  function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < int'(DATA_W / 8); b++) begin
      r[8*b +: 8] = v[int'(DATA_W) - 8 - 8*b +: 8];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] cmp_data;
  logic              wr_event;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              in_window;
  logic              hit;

  assign cmp_data  = SWAP ? byte_rev(data) : data;
  // Rising edge of wen: a long write strobe counts once.
  assign wr_event  = wen & ~wen_q;
  assign offset    = addr - BASE_ADDR;
  assign idx       = offset[IDX_W-1:0];
  assign in_window = (offset != '0) && (offset < ADDR_W'(NUM_CHK));
  assign hit       = wr_event && in_window && !done_q[idx];

  always_ff @(posedge clk) begin
    if (state_q == StIdle && ld_en && (32'(ld_idx) < NUM_CHK)) begin
      table_q[ld_idx] <= ld_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    dur_d        = dur_q;
    tmo_d        = tmo_q;
    chk_d        = chk_q;
    done_d       = done_q;
    first_seen_d = first_seen_q;
    fidx_d       = fidx_q;
    fdata_d      = fdata_q;
    pen_sum      = '0;

    unique case (state_q)
      StIdle: begin
        if (wr_event && addr == BASE_ADDR && cmp_data == table_q[0]) begin
          state_d   = StCheck;
          err_d     = 8'd0;
          chk_d     = (IDX_W+1)'(1);
          done_d    = '0;
          done_d[0] = 1'b1;
          dur_d     = 16'd0;
        end
      end

      StCheck: begin
        if (dur_q != 16'hFFFF) begin
          dur_d = dur_q + 16'd1;
        end
        if (hit) begin
          done_d[idx] = 1'b1;
          chk_d       = chk_q + (IDX_W+1)'(1);
          if (cmp_data != table_q[idx]) begin
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
            if (!first_seen_q) begin
              first_seen_d = 1'b1;
              fidx_d       = idx;
              fdata_d      = cmp_data;
            end
          end
        end
        if (chk_q == NumChkW) begin
          state_d = StReport;
        end else if (dur_q == TIMEOUT_CYC && chk_d != NumChkW) begin
          // A checkpoint completing the set on the limit cycle beats the timeout.
          state_d = StReport;
          tmo_d   = 1'b1;
          dur_d   = dur_q;
          pen_sum = 10'(err_d) + 10'(NUM_CHK) - 10'(chk_d);
          err_d   = (pen_sum > 10'd255) ? 8'hFF : pen_sum[7:0];
        end
      end

      StReport: ;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wen_q        <= 1'b0;
      err_q        <= 8'hFF;
      dur_q        <= 16'd0;
      tmo_q        <= 1'b0;
      chk_q        <= '0;
      done_q       <= '0;
      first_seen_q <= 1'b0;
      fidx_q       <= '1;
      fdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      wen_q        <= wen;
      err_q        <= err_d;
      dur_q        <= dur_d;
      tmo_q        <= tmo_d;
      chk_q        <= chk_d;
      done_q       <= done_d;
      first_seen_q <= first_seen_d;
      fidx_q       <= fidx_d;
      fdata_q      <= fdata_d;
    end
  end

  assign error_num      = err_q;
  assign duration       = dur_q;
  assign finish         = (state_q == StReport);
  assign timeout        = tmo_q;
  assign checked        = chk_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdata_q;

endmodule

// File: tb/tb_mem_write_scoreboard.sv
// Bench for mem_write_scoreboard: instance a uses defaults (byte-swapped compare),
// instance b uses SWAP=0 and a 100-cycle limit. Both share all inputs; the
// swapped and unswapped bus values differ, so only the intended instance starts.
module tb_mem_write_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [3:0]  ld_idx;
  logic [31:0] ld_data;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;

  logic [7:0]  a_err, b_err;
  logic [15:0] a_dur, b_dur;
  logic        a_fin, b_fin, a_tmo, b_tmo;
  logic [4:0]  a_chk, b_chk;
  logic [3:0]  a_fidx, b_fidx;
  logic [31:0] a_fdata, b_fdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_write_scoreboard dut_a (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .addr(addr), .data(data), .wen(wen),
    .error_num(a_err), .duration(a_dur), .finish(a_fin), .timeout(a_tmo),
    .checked(a_chk), .first_err_idx(a_fidx), .first_err_data(a_fdata)
  );

  mem_write_scoreboard #(.SWAP(1'b0), .TIMEOUT_CYC(16'd100)) dut_b (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
    .addr(addr), .data(data), .wen(wen),
    .error_num(b_err), .duration(b_dur), .finish(b_fin), .timeout(b_tmo),
    .checked(b_chk), .first_err_idx(b_fidx), .first_err_data(b_fdata)
  );

  typedef struct {
    int          idx;
    logic [31:0] val;
    int          hold;
    logic [4:0]  exp_chk;
    logic [7:0]  exp_err;
    logic [3:0]  exp_fidx;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [31:0] tval(input int i);
    return (i == 5) ? 32'h0000_0003 : 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int i, input logic [31:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_idx = 4'(i); ld_data = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input int hold);
    @(negedge clk);
    addr = 30'(a); data = d; wen = 1'b1;
    repeat (hold) @(negedge clk);
    wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Run 1: mixed pattern on instance a; second mismatch must not move first_err.
    vecs[0]  = '{0,  tval(0),          1, 5'd1,  8'd0, 4'hF};
    vecs[1]  = '{1,  tval(1),          1, 5'd2,  8'd0, 4'hF};
    vecs[2]  = '{2,  tval(2),          4, 5'd3,  8'd0, 4'hF};
    vecs[3]  = '{2,  32'hDEAD_BEEF,    1, 5'd3,  8'd0, 4'hF};
    vecs[4]  = '{5,  32'h0000_0004,    1, 5'd4,  8'd1, 4'd5};
    vecs[5]  = '{3,  tval(3),          1, 5'd5,  8'd1, 4'd5};
    vecs[6]  = '{20, tval(3),          1, 5'd5,  8'd1, 4'd5};
    vecs[7]  = '{4,  tval(4),          1, 5'd6,  8'd1, 4'd5};
    vecs[8]  = '{6,  tval(6),          1, 5'd7,  8'd1, 4'd5};
    vecs[9]  = '{7,  32'h1234_5678,    1, 5'd8,  8'd2, 4'd5};
    vecs[10] = '{8,  tval(8),          1, 5'd9,  8'd2, 4'd5};
    vecs[11] = '{9,  tval(9),          1, 5'd10, 8'd2, 4'd5};
    vecs[12] = '{10, tval(10),         1, 5'd11, 8'd2, 4'd5};
    vecs[13] = '{11, tval(11),         1, 5'd12, 8'd2, 4'd5};
    vecs[14] = '{12, tval(12),         2, 5'd13, 8'd2, 4'd5};
    vecs[15] = '{0,  tval(0),          1, 5'd13, 8'd2, 4'd5};
    vecs[16] = '{14, 32'hFFFF_FFFF,    1, 5'd13, 8'd2, 4'd5};
    vecs[17] = '{12, 32'h0,            1, 5'd13, 8'd2, 4'd5};
    vecs[18] = '{13, tval(13),         1, 5'd14, 8'd2, 4'd5};

    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    addr = '0; data = '0; wen = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_err", a_err, 8'hFF);
    chk("reset_dur", a_dur, 16'd0);
    chk("reset_fin", a_fin, 1'b0);
    chk("reset_tmo", a_tmo, 1'b0);
    chk("reset_chk", a_chk, 5'd0);
    chk("reset_fidx", a_fidx, 4'hF);
    chk("reset_fdata", a_fdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) load(i, tval(i));

    for (int k = 0; k < 19; k++) begin
      do_write(vecs[k].idx, swap32(vecs[k].val), vecs[k].hold);
      chk($sformatf("v%0d_checked", k), a_chk, vecs[k].exp_chk);
      chk($sformatf("v%0d_err", k), a_err, vecs[k].exp_err);
      chk($sformatf("v%0d_fidx", k), a_fidx, vecs[k].exp_fidx);
    end
    chk("run1_finish", a_fin, 1'b1);
    chk("run1_fdata", a_fdata, 32'h0000_0004);
    chk("run1_tmo", a_tmo, 1'b0);

    // Run 2: all checkpoints correct.
    rst_pulse();
    for (int i = 0; i < 14; i++) do_write(i, swap32(tval(i)), 1);
    chk("run2_finish", a_fin, 1'b1);
    chk("run2_err", a_err, 8'd0);
    chk("run2_chk", a_chk, 5'd14);
    chk("run2_fidx", a_fidx, 4'hF);
    chk("run2_fdata", a_fdata, 32'd0);
    chk("run2_tmo", a_tmo, 1'b0);

    // Run 3: no start on wrong data / other index; load ignored in CHECK;
    // reset mid-run abandons it but keeps the table.
    rst_pulse();
    do_write(0, swap32(32'h0BAD_0000), 1);
    chk("run3_badstart_err", a_err, 8'hFF);
    chk("run3_badstart_chk", a_chk, 5'd0);
    do_write(3, swap32(tval(3)), 1);
    chk("run3_idle_other_err", a_err, 8'hFF);
    do_write(0, swap32(tval(0)), 1);
    chk("run3_start_err", a_err, 8'd0);
    chk("run3_start_chk", a_chk, 5'd1);
    chk("run3_start_dur", a_dur, 16'd1);
    load(1, 32'h0000_0BAD);
    do_write(1, swap32(tval(1)), 1);
    chk("run3_ldignored_err", a_err, 8'd0);
    chk("run3_ldignored_chk", a_chk, 5'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("run3_async_err", a_err, 8'hFF);
    chk("run3_async_chk", a_chk, 5'd0);
    chk("run3_async_dur", a_dur, 16'd0);
    chk("run3_async_fin", a_fin, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_write(1, swap32(tval(1)), 1);
    chk("run3_norestart_chk", a_chk, 5'd0);
    chk("run3_norestart_err", a_err, 8'hFF);
    do_write(0, swap32(tval(0)), 1);
    chk("run3_restart_chk", a_chk, 5'd1);
    chk("run3_restart_err", a_err, 8'd0);

    // Instance b saw the ignored-by-a load while idle; restore its table.
    rst_pulse();
    load(1, tval(1));

    // Run 4: instance b times out with checkpoints 10..13 missing.
    for (int i = 0; i < 10; i++) do_write(i, tval(i), 1);
    for (int c = 0; c < 300 && !b_fin; c++) @(negedge clk);
    chk("run4_finish", b_fin, 1'b1);
    chk("run4_tmo", b_tmo, 1'b1);
    chk("run4_err", b_err, 8'd4);
    chk("run4_dur", b_dur, 16'd100);
    chk("run4_chk", b_chk, 5'd10);
    repeat (5) @(negedge clk);
    chk("run4_frozen_dur", b_dur, 16'd100);
    chk("run4_a_idle", a_err, 8'hFF);

    // Run 5: unswapped compare on instance b, all correct.
    rst_pulse();
    for (int i = 0; i < 14; i++) do_write(i, tval(i), 1);
    chk("run5_finish", b_fin, 1'b1);
    chk("run5_err", b_err, 8'd0);
    chk("run5_tmo", b_tmo, 1'b0);

    // Run 6: final checkpoint lands on the limit cycle; completion wins.
    rst_pulse();
    for (int i = 0; i < 13; i++) do_write(i, tval(i), 1);
    for (int c = 0; c < 300 && b_dur != 16'd100; c++) @(negedge clk);
    chk("run6_reach_limit", b_dur, 16'd100);
    addr = 30'd13; data = tval(13); wen = 1'b1;
    @(negedge clk);
    wen = 1'b0;
    repeat (2) @(negedge clk);
    chk("run6_finish", b_fin, 1'b1);
    chk("run6_tmo", b_tmo, 1'b0);
    chk("run6_err", b_err, 8'd0);
    chk("run6_chk", b_chk, 5'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_write_scoreboard.md
MEM_WRITE_SCOREBOARD -- requirements
Module: mem_write_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 30, word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter NUM_CHK, default 14, checkpoint count (2..64); IDX_W = clog2(NUM_CHK).
REQ-004 SHALL have parameter BASE_ADDR, default 0, word address of checkpoint 0.
REQ-005 SHALL have parameter SWAP, default 1; 1 = byte-reverse data before compare (little-endian bus), 0 = compare as-is.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 16'hFFFF, CHECK-state cycle limit.
REQ-007 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 ld_en  in  1  answer-table write strobe.
REQ-010 ld_idx  in  IDX_W  answer-table index.
REQ-011 ld_data  in  DATA_W  expected value (readable order).
REQ-012 addr  in  ADDR_W  monitored memory word address.
REQ-013 data  in  DATA_W  monitored write data.
REQ-014 wen  in  1  monitored write enable (may stay high several cycles per write).
REQ-015 error_num  out  8  mismatch count; 255 = not started.
REQ-016 duration  out  16  CHECK-state cycle count.
REQ-017 finish  out  1  high while in REPORT.
REQ-018 timeout  out  1  REPORT reached by timeout.
REQ-019 checked  out  IDX_W+1  distinct checkpoints seen.
REQ-020 first_err_idx  out  IDX_W  index of first mismatch; all-ones = none.
REQ-021 first_err_data  out  DATA_W  swapped data of first mismatch.

Function
REQ-022 Write event SHALL be wen=1 with registered previous wen=0; wen held high produces exactly one event.
REQ-023 Compare data SHALL be byte-reversed when SWAP=1, unmodified when SWAP=0.
REQ-024 States SHALL be IDLE, CHECK, REPORT; encoding free.
REQ-025 In IDLE, ld_en=1 SHALL write ld_data to table[ld_idx] that cycle; ld_idx>=NUM_CHK ignored; ld_en ignored outside IDLE.
REQ-026 IDLE->CHECK SHALL occur on write event with addr==BASE_ADDR and compare data==table[0]; next cycle error_num=0, checked=1, done bit 0 set, duration=0.
REQ-027 Any other IDLE write event SHALL be ignored; error_num stays 255.
REQ-028 In CHECK, duration SHALL increment every cycle, saturating at 16'hFFFF.
REQ-029 CHECK write event with addr-BASE_ADDR = i, 1<=i<NUM_CHK, done[i]=0: set done[i], checked+1; mismatch vs table[i] increments error_num (saturate 255).
REQ-030 First mismatch in CHECK SHALL latch first_err_idx=i and first_err_data; later mismatches do not overwrite.
REQ-031 Write events outside the window or to already-done indices SHALL be ignored (no count, no error).
REQ-032 CHECK->REPORT SHALL occur the cycle after checked reaches NUM_CHK; timeout=0.
REQ-033 CHECK->REPORT with timeout=1 SHALL occur when duration==TIMEOUT_CYC and checked<NUM_CHK; error_num += NUM_CHK-checked, saturating at 255.
REQ-034 Completion and timeout in the same cycle: completion wins, timeout=0, no penalty added.
REQ-035 REPORT SHALL freeze all outputs, finish=1 (combinational from state), exit only via rst.
REQ-036 Event on an index and first-mismatch capture in the same cycle SHALL both take effect.

Reset
REQ-037 rst=1 SHALL immediately force IDLE, error_num=255, duration=0, finish=0, timeout=0, checked=0, first_err_idx=all-ones, first_err_data=0, done=0, previous-wen=0.
REQ-038 Answer table SHALL NOT be cleared by rst.
REQ-039 rst asserted mid-CHECK SHALL abandon the run; after release a new run needs a fresh checkpoint-0 match.

Verification
REQ-040 Defaults, table loaded; writes 0..13 all matching, byte-swapped -> finish=1, error_num=0, checked=14, first_err_idx=all-ones.
REQ-041 Index 5 write 0x00000004 (expected 0x00000003), others correct -> error_num=1, first_err_idx=5, first_err_data=0x00000004.
REQ-042 wen held 4 cycles on index 2, then index 2 rewritten with wrong data -> checked +1 only, error_num unchanged.
REQ-043 TIMEOUT_CYC=100, only indices 0..9 written -> at duration 100 timeout=1, finish=1, error_num=4.
REQ-044 Index-0 write with wrong data -> stays IDLE, error_num=255; rst pulse mid-CHECK -> IDLE, outputs at reset values, table intact.
REQ-045 SWAP=0 instance, unswapped data matching -> error_num=0; last write coinciding with timeout cycle -> timeout=0.
